ripple_carry_counter: RTL and testbench



---
 rtl/ripple_carry_counter_pkg.sv | 9 +
 rtl/ripple_carry_counter_tff.sv | 18 +
 rtl/ripple_carry_counter.sv | 32 +++
 tb/tb_ripple_carry_counter.sv | 107 ++++++++++
 4 files changed

// File: rtl/ripple_carry_counter_pkg.sv
// Shared definitions for the ripple-carry up-counter and its instantiators.
package ripple_carry_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/ripple_carry_counter_tff.sv
// Falling-edge toggle flip-flop with synchronous active-high clear.
module ripple_carry_counter_tff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    // Clear wins over toggle so a held reset pins the stage at zero.
    always_ff @(negedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/ripple_carry_counter.sv
// Free-running binary up-counter built from toggle flops and a ripple carry chain.
module ripple_carry_counter
    import ripple_carry_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] t;

    // A stage toggles only when every lower stage is already at one.
    always_comb begin
        t    = '0;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & q[i-1];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        ripple_carry_counter_tff u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (t[i]),
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_ripple_carry_counter.sv
// Randomized self-checking bench for ripple_carry_counter at WIDTH=4 and WIDTH=8.
module tb_ripple_carry_counter;

    logic       clk;
    logic       reset;
    logic       reset8;
    logic [3:0] q;
    logic [7:0] q8;

    int errors = 0;
    int checks = 0;
    int exp4   = 0;
    int exp8   = 0;

    ripple_carry_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    ripple_carry_counter #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic applyStimulus(input logic r4, input logic r8);
        reset  = r4;
        reset8 = r8;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (q === 4'(exp4)) else begin
            errors++;
            $error("[TB] FAIL %s q observed=%0d expected=%0d", tag, q, exp4);
        end
        checks++;
        assert (q8 === 8'(exp8)) else begin
            errors++;
            $error("[TB] FAIL %s q8 observed=%0d expected=%0d", tag, q8, exp8);
        end
    endtask

    // The model only knows the counting rule: reset clears, otherwise add one modulo 2^WIDTH.
    task automatic tick(input string tag);
        logic r4, r8;
        r4 = reset;
        r8 = reset8;
        @(negedge clk);
        exp4 = r4 ? 0 : (exp4 + 1) % 16;
        exp8 = r8 ? 0 : (exp8 + 1) % 256;
        #2;
        checkOutput(tag);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1);
        tick("reset_hold");
        #3;
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 19; i++) tick("count_wrap");

        applyStimulus(1'b1, 1'b0);
        tick("mid_reset");
        applyStimulus(1'b0, 1'b0);
        tick("resume_1");
        tick("resume_2");

        for (int k = 0; k < 3; k++) begin
            #2;
            applyStimulus(1'b1, 1'b1);
            #2;
            applyStimulus(1'b0, 1'b0);
            checkOutput("rise_glitch_hold");
            tick("rise_glitch_count");
        end

        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
            tick("random");
        end

        applyStimulus(1'b0, 1'b1);
        tick("w8_reset");
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            if (exp8 == 8'h0F)      tick("w8_carry_0f_10");
            else if (exp8 == 8'h7F) tick("w8_carry_7f_80");
            else if (exp8 == 8'hFF) tick("w8_wrap");
            else                    tick("w8_count");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
